// File: rtl/traffic_light_controller.sv
// traffic_light_controller: fixed-time six-phase sequencer for a T-junction.
// Moore FSM with an 8-bit phase counter; lamp outputs decode from state only.
`default_nettype none

module traffic_light_controller #(
  parameter int T_MAIN = 7,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam logic [2:0] c_GRN = 3'b001;
  localparam logic [2:0] c_YEL = 3'b010;
  localparam logic [2:0] c_RED = 3'b100;

  localparam logic [7:0] c_MAIN_LAST = 8'(T_MAIN - 1);
  localparam logic [7:0] c_TURN_LAST = 8'(T_TURN - 1);
  localparam logic [7:0] c_SIDE_LAST = 8'(T_SIDE - 1);
  localparam logic [7:0] c_YEL_LAST  = 8'(T_YEL - 1);

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } state_t;

  state_t     state_q, state_d, next_state;
  logic [7:0] cnt_q, cnt_d, last_cnt;
  logic       illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    next_state = S1;
    last_cnt   = c_MAIN_LAST;
    illegal    = 1'b0;
    case (state_q)
      S1:      begin last_cnt = c_MAIN_LAST; next_state = S2; end
      S2:      begin last_cnt = c_YEL_LAST;  next_state = S3; end
      S3:      begin last_cnt = c_TURN_LAST; next_state = S4; end
      S4:      begin last_cnt = c_YEL_LAST;  next_state = S5; end
      S5:      begin last_cnt = c_SIDE_LAST; next_state = S6; end
      S6:      begin last_cnt = c_YEL_LAST;  next_state = S1; end
      default: illegal = 1'b1;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    // Unreachable encodings fall straight back to the start of the cycle.
    if (illegal) begin
      state_d = S1;
      cnt_d   = 8'd0;
    end else if (cnt_q == last_cnt) begin
      state_d = next_state;
      cnt_d   = 8'd0;
    end
  end

  always_comb begin
    light_M1 = c_RED;
    light_M2 = c_RED;
    light_MT = c_RED;
    light_S  = c_RED;
    case (state_q)
      S1: begin light_M1 = c_GRN; light_M2 = c_GRN; end
      S2: begin light_M1 = c_GRN; light_M2 = c_YEL; end
      S3: begin light_M1 = c_GRN; light_MT = c_GRN; end
      S4: begin light_M1 = c_YEL; light_MT = c_YEL; end
      S5: light_S = c_GRN;
      S6: light_S = c_YEL;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: default-timing DUT and an all-ones-duration DUT share clk/rst.
`default_nettype none

module tb_traffic_light_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;

  logic [2:0] d_m1, d_s, d_mt, d_m2;
  logic [2:0] f_m1, f_s, f_mt, f_m2;

  traffic_light_controller dut (
    .clk(clk), .rst(rst),
    .light_M1(d_m1), .light_S(d_s), .light_MT(d_mt), .light_M2(d_m2)
  );

  traffic_light_controller #(.T_MAIN(1), .T_TURN(1), .T_SIDE(1), .T_YEL(1)) dut_fast (
    .clk(clk), .rst(rst),
    .light_M1(f_m1), .light_S(f_s), .light_MT(f_mt), .light_M2(f_m2)
  );

  typedef struct packed {
    logic [11:0] d;
    logic [11:0] f;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Packed as {M1, M2, MT, S}.
  function automatic logic [11:0] phase_code(input int ph);
    case (ph)
      0: return {3'b001, 3'b001, 3'b100, 3'b100};
      1: return {3'b001, 3'b010, 3'b100, 3'b100};
      2: return {3'b001, 3'b100, 3'b001, 3'b100};
      3: return {3'b010, 3'b100, 3'b010, 3'b100};
      4: return {3'b100, 3'b100, 3'b100, 3'b001};
      default: return {3'b100, 3'b100, 3'b100, 3'b010};
    endcase
  endfunction

  // Default timing: phase boundaries at 7, 9, 14, 16, 19, period 21.
  function automatic int phase_default(input int k);
    int p;
    p = k % 21;
    if (p < 7)  return 0;
    if (p < 9)  return 1;
    if (p < 14) return 2;
    if (p < 16) return 3;
    if (p < 19) return 4;
    return 5;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic safety(input string name, input logic [2:0] m1, input logic [2:0] m2,
                        input logic [2:0] mt, input logic [2:0] s);
    logic ok;
    ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
    if (s != 3'b100 && !(m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100)) ok = 1'b0;
    if (m2 != 3'b100 && mt != 3'b100) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: lamps M1=%b M2=%b MT=%b S=%b required safe one-hot set",
               name, m1, m2, mt, s);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (clk_en) begin
      safety("safety_default", d_m1, d_m2, d_mt, d_s);
      safety("safety_fast", f_m1, f_m2, f_mt, f_s);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("seq_default", {d_m1, d_m2, d_mt, d_s}, e.d);
        check("seq_fast", {f_m1, f_m2, f_mt, f_s}, e.f);
      end
    end
  end

  // Release reset just after a rising edge, then queue one expectation per cycle.
  task automatic run_from_release(input int n);
    exp_t e;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(posedge clk);
      e.d = phase_code(phase_default(k));
      e.f = phase_code(k % 6);
      q.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #10;
    check("reset_default", {d_m1, d_m2, d_mt, d_s}, phase_code(0));
    check("reset_fast", {f_m1, f_m2, f_mt, f_s}, phase_code(0));

    clk_en = 1'b1;
    run_from_release(50);

    rst = 1'b0;
    run_from_release(11);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_default", {d_m1, d_m2, d_mt, d_s}, phase_code(0));
    check("async_reset_fast", {f_m1, f_m2, f_mt, f_s}, phase_code(0));
    run_from_release(10);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_light_controller.md
# traffic_light_controller

Fixed-time traffic signal sequencer for a T-junction with two main-road approaches (M1, M2), a main-road right-turn lane (MT) and a side road (S). It cycles through six phases with parameterised durations and drives one 3-bit one-hot lamp code per approach. It is a free-running leaf block with no sensor inputs, clocked by the system clock and placed directly in front of the lamp drivers.

## Interface
- T_MAIN, default 7: cycles of phase S1 (M1 and M2 green).
- T_TURN, default 5: cycles of phase S3 (M1 and MT green).
- T_SIDE, default 3: cycles of phase S5 (S green).
- T_YEL, default 2: cycles of each yellow phase (S2, S4, S6).
- All durations are legal in the range 1..255 and are counted by an 8-bit phase counter.
- clk  input  1  system clock; all state changes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- light_M1  output  3  main road direction 1 lamp.
- light_S  output  3  side road lamp.
- light_MT  output  3  main road turn lane lamp.
- light_M2  output  3  main road direction 2 lamp.
- Lamp encoding is one-hot: 3'b001 is green, 3'b010 is yellow, 3'b100 is red. No other value is ever driven.

## Operation
- A Moore FSM has six states. Outputs are decoded combinationally from the state register only.
  - S1: M1=G, M2=G, MT=R, S=R. Duration T_MAIN.
  - S2: M1=G, M2=Y, MT=R, S=R. Duration T_YEL.
  - S3: M1=G, M2=R, MT=G, S=R. Duration T_TURN.
  - S4: M1=Y, M2=R, MT=Y, S=R. Duration T_YEL.
  - S5: M1=R, M2=R, MT=R, S=G. Duration T_SIDE.
  - S6: M1=R, M2=R, MT=R, S=Y. Duration T_YEL.
  - After S6 the FSM returns to S1.
- Transitions are unconditional and driven only by the 8-bit phase counter.
- Safety invariants:
  - S is never green or yellow unless M1, M2 and MT are all red.
  - M2 and MT are never both non-red.
  - Every approach passes through yellow before red.
- An illegal state (unreachable encodings) recovers to S1 with the counter set to 0 on the next rising edge.

## Timing
- Reset (rst=0):
  - Immediately and asynchronously forces state S1 and counter 0.
  - Outputs become M1=001, M2=001, MT=100, S=100 without waiting for a clock edge.
  - The state holds for as long as rst is low.
- Counter rule on each rising edge with rst=1:
  - If counter == duration(state)-1, advance to the next state and clear the counter.
  - Otherwise, increment the counter.
- Each phase is therefore visible for exactly its duration in clock cycles.
- With default parameters the full period is 7+2+5+2+3+2 = 21 cycles. Output changes occur after rising edges 7, 9, 14, 16, 19 and 21, counted from the first rising edge after reset release.
- A duration of 1 gives a single-cycle phase. This requires no special case.
- Reset asserted mid-phase aborts that phase at once. Phase S1 restarts with its full T_MAIN after rst is released.
- Reset released coincident with a rising edge: that edge is ignored, and counting starts at the following edge.
- Latency from state register to outputs is zero cycles, because outputs are combinational from the state.

## Test plan
- Reset values: hold rst=0 with no clock -> M1=001, M2=001, MT=100, S=100.
- Full default cycle: release rst, run 21 cycles -> phase sequence S1(7) S2(2) S3(5) S4(2) S5(3) S6(2), with lamp codes exactly as listed per phase, back in S1 at edge 21.
- Periodicity: run 50 cycles from reset -> outputs at cycle n equal outputs at cycle n+21 for all sampled n.
- Async reset mid-phase: assert rst=0 between edges during S3 -> outputs return to S1 values immediately. After release, S1 lasts the full 7 cycles.
- Safety assertions on every cycle: S != 100 implies M1 = M2 = MT = 100; never (M2 != 100 and MT != 100); all outputs one-hot.
- Parameter override: T_MAIN=1, T_TURN=1, T_SIDE=1, T_YEL=1 -> state advances every cycle, 6-cycle period, same sequence order.
